// File: rtl/risac_bus_arbiter.sv
// Two-master Avalon-MM arbiter: risac instruction and data buses share one slave port,
// with a wait-timeout watchdog. Define ARB_ROUND_ROBIN_EN for alternating tie-break.
module risac_bus_arbiter #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ib_address,
    input  logic          ib_read,
    output logic [31:0]   ib_readdata,
    output logic          ib_waitrequest,
    input  logic [AW-1:0] db_address,
    input  logic          db_read,
    input  logic          db_write,
    input  logic [31:0]   db_writedata,
    input  logic [3:0]    db_byteenable,
    output logic [31:0]   db_readdata,
    output logic          db_waitrequest,
    output logic [AW-1:0] m_address,
    output logic          m_read,
    output logic          m_write,
    output logic [31:0]   m_writedata,
    output logic [3:0]    m_byteenable,
    input  logic [31:0]   m_readdata,
    input  logic          m_waitrequest,
    output logic          timeout_err
);

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      state, state_nxt;
    logic        db_req, req_live, wd_hit, prefer_d;
    logic        ib_done, db_done;
    logic [31:0] ib_rd_q, db_rd_q, done_data;

    assign db_req    = db_read | db_write;
    assign req_live  = (state == GNT_I) ? ib_read : ((state == GNT_D) ? db_req : 1'b0);
    assign done_data = wd_hit ? ABORT_DATA : m_readdata;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which master won last; 0 = instruction.
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && state_nxt != IDLE) begin
            last_d <= (state_nxt == GNT_D);
        end
    end

    assign prefer_d = ~last_d;
`else
    assign prefer_d = 1'b1;
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [CW-1:0] wait_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wait_cnt <= '0;
                end else if (state == IDLE || state_nxt == IDLE) begin
                    wait_cnt <= '0;
                end else if (m_waitrequest) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end

            // A dropped request is not a stuck slave, so it never trips the watchdog.
            assign wd_hit = req_live && m_waitrequest && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign wd_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave a latch behind.
        state_nxt      = state;
        m_address      = '0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_writedata    = '0;
        m_byteenable   = '0;
        ib_waitrequest = 1'b1;
        db_waitrequest = 1'b1;
        ib_done        = 1'b0;
        db_done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (db_req && ib_read) state_nxt = prefer_d ? GNT_D : GNT_I;
                else if (db_req)       state_nxt = GNT_D;
                else if (ib_read)      state_nxt = GNT_I;
            end
            GNT_I: begin
                m_address      = ib_address;
                m_read         = ib_read & ~wd_hit;
                m_byteenable   = 4'hF;
                ib_waitrequest = m_waitrequest & ~wd_hit;
                ib_done        = ib_read & (wd_hit | ~m_waitrequest);
                if (!ib_read || ib_done) state_nxt = IDLE;
            end
            GNT_D: begin
                m_address      = db_address;
                m_read         = db_read & ~wd_hit;
                m_write        = db_write & ~wd_hit;
                m_writedata    = db_writedata;
                m_byteenable   = db_byteenable;
                db_waitrequest = m_waitrequest & ~wd_hit;
                db_done        = db_req & (wd_hit | ~m_waitrequest);
                if (!db_req || db_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion data is visible in the completing cycle, then held for a late sample.
    assign ib_readdata = ib_done ? done_data : ib_rd_q;
    assign db_readdata = db_done ? done_data : db_rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state       <= IDLE;
            ib_rd_q     <= '0;
            db_rd_q     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ib_done) ib_rd_q <= done_data;
            if (db_done) db_rd_q <= done_data;
            if (wd_hit)  timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_risac_bus_arbiter.sv
// Bench for risac_bus_arbiter: per-cycle transaction-level model plus directed scenarios
// with hand-computed expectations (watchdog set to 8 cycles).
module tb_risac_bus_arbiter;

    localparam int AW = 32;
    localparam int TO = 8;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] ib_address = '0;
    logic          ib_read = 1'b0;
    logic [31:0]   ib_readdata;
    logic          ib_waitrequest;
    logic [AW-1:0] db_address = '0;
    logic          db_read = 1'b0;
    logic          db_write = 1'b0;
    logic [31:0]   db_writedata = '0;
    logic [3:0]    db_byteenable = '0;
    logic [31:0]   db_readdata;
    logic          db_waitrequest;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [31:0]   m_writedata;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_readdata = '0;
    logic          m_waitrequest = 1'b1;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    risac_bus_arbiter #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ib_address(ib_address), .ib_read(ib_read),
        .ib_readdata(ib_readdata), .ib_waitrequest(ib_waitrequest),
        .db_address(db_address), .db_read(db_read), .db_write(db_write),
        .db_writedata(db_writedata), .db_byteenable(db_byteenable),
        .db_readdata(db_readdata), .db_waitrequest(db_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the slave, how long it has waited, held read data.
    int          own = 0;      // 0 none, 1 instruction, 2 data
    int          waited = 0;
    bit          err = 1'b0;
    bit          last_d = 1'b0;
    logic [31:0] ihold = '0, dhold = '0;

    function automatic bit data_wins_tie(input bit last_was_data);
`ifdef ARB_ROUND_ROBIN_EN
        return !last_was_data;
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] e_ma, e_wd, e_ird, e_drd;
        logic        e_mr, e_mw, e_iw, e_dw;
        logic [3:0]  e_be;
        bit          req, abort, done, dreq;
        if (!rst_n) begin
            own = 0; waited = 0; err = 1'b0; last_d = 1'b0; ihold = '0; dhold = '0;
        end
        e_ma = '0; e_wd = '0; e_be = '0; e_mr = 1'b0; e_mw = 1'b0;
        e_iw = 1'b1; e_dw = 1'b1; e_ird = ihold; e_drd = dhold;
        req = 1'b0; abort = 1'b0; done = 1'b0;
        if (rst_n && own != 0) begin
            req   = (own == 1) ? ib_read : (db_read | db_write);
            abort = (TO > 0) && req && m_waitrequest && (waited == TO - 1);
            done  = req && (abort || !m_waitrequest);
            if (own == 1) begin
                e_ma = ib_address; e_mr = ib_read && !abort; e_be = 4'hF;
                e_iw = abort ? 1'b0 : m_waitrequest;
                if (done) e_ird = abort ? DEAD : m_readdata;
            end else begin
                e_ma = db_address; e_mr = db_read && !abort; e_mw = db_write && !abort;
                e_wd = db_writedata; e_be = db_byteenable;
                e_dw = abort ? 1'b0 : m_waitrequest;
                if (done) e_drd = abort ? DEAD : m_readdata;
            end
        end
        check("cmp_m_address", m_address, e_ma);
        check("cmp_m_read", 32'(m_read), 32'(e_mr));
        check("cmp_m_write", 32'(m_write), 32'(e_mw));
        check("cmp_m_writedata", m_writedata, e_wd);
        check("cmp_m_byteenable", 32'(m_byteenable), 32'(e_be));
        check("cmp_ib_waitrequest", 32'(ib_waitrequest), 32'(e_iw));
        check("cmp_db_waitrequest", 32'(db_waitrequest), 32'(e_dw));
        check("cmp_ib_readdata", ib_readdata, e_ird);
        check("cmp_db_readdata", db_readdata, e_drd);
        check("cmp_timeout_err", 32'(timeout_err), 32'(err));
        if (rst_n) begin
            if (own == 0) begin
                dreq = db_read | db_write;
                if (dreq && ib_read) own = data_wins_tie(last_d) ? 2 : 1;
                else if (dreq)       own = 2;
                else if (ib_read)    own = 1;
                if (own != 0) last_d = (own == 2);
                waited = 0;
            end else if (!req || done) begin
                ihold = e_ird; dhold = e_drd;
                if (abort) err = 1'b1;
                own = 0; waited = 0;
            end else if (m_waitrequest) begin
                waited++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        int ng;
        bit got;
        int order [5];

        #1 rst_n = 1'b0;
        obs(); obs();
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_ib_waitrequest", 32'(ib_waitrequest), 32'd1);
        check("rst_db_readdata", db_readdata, 32'd0);
        nxt(); rst_n = 1'b1;

        // Single instruction read, two slave wait cycles.
        nxt(); ib_address = 32'h100; ib_read = 1'b1; m_waitrequest = 1'b1; m_readdata = 32'h13;
        obs(); check("t1_arb_m_read", 32'(m_read), 32'd0);
        cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            nxt(); m_waitrequest = (c == 3) ? 1'b0 : 1'b1;
            obs(); if (m_read) cnt++;
            if (c == 2) check("t1_wait_cycle2", 32'(ib_waitrequest), 32'd1);
            if (c == 3) begin
                check("t1_ib_waitrequest_fall", 32'(ib_waitrequest), 32'd0);
                check("t1_ib_readdata", ib_readdata, 32'h13);
            end
        end
        nxt(); ib_read = 1'b0; m_waitrequest = 1'b1; m_readdata = 32'h55;
        obs();
        check("t1_m_read_cycles", 32'(cnt), 32'd3);
        check("t1_ib_readdata_hold", ib_readdata, 32'h13);

        // Zero-wait data write.
        nxt(); db_address = 32'h2004; db_writedata = 32'hA5A5_A5A5; db_byteenable = 4'b0011;
        db_write = 1'b1; m_waitrequest = 1'b0;
        obs(); cnt = m_write ? 1 : 0;
        nxt(); obs(); if (m_write) cnt++;
        check("t2_m_address", m_address, 32'h2004);
        check("t2_m_writedata", m_writedata, 32'hA5A5_A5A5);
        check("t2_m_byteenable", 32'(m_byteenable), 32'h3);
        check("t2_ib_waitrequest", 32'(ib_waitrequest), 32'd1);
        nxt(); db_write = 1'b0; obs(); if (m_write) cnt++;
        check("t2_m_write_cycles", 32'(cnt), 32'd1);

        // Contention from a fresh reset: four contended grants, then instruction alone.
        nxt(); rst_n = 1'b0; obs();
        nxt(); rst_n = 1'b1;
        ib_address = 32'h400; db_address = 32'h800; ib_read = 1'b1; db_read = 1'b1;
        m_waitrequest = 1'b0; m_readdata = 32'h1111;
        for (int k = 0; k < 5; k++) order[k] = 0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            obs();
            if (!db_waitrequest) begin order[ng] = 2; ng++; end
            else if (!ib_waitrequest) begin order[ng] = 1; ng++; end
            nxt();
        end
        db_read = 1'b0;
        for (int c = 0; c < 10 && ng < 5; c++) begin
            obs();
            if (!ib_waitrequest) begin order[ng] = 1; ng++; end
            else if (!db_waitrequest) begin order[ng] = 2; ng++; end
            nxt();
        end
        ib_read = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_grant0", 32'(order[0]), 32'd2);
        check("t3_grant1", 32'(order[1]), 32'd1);
        check("t3_grant2", 32'(order[2]), 32'd2);
        check("t3_grant3", 32'(order[3]), 32'd1);
`else
        check("t3_grant0", 32'(order[0]), 32'd2);
        check("t3_grant1", 32'(order[1]), 32'd2);
        check("t3_grant2", 32'(order[2]), 32'd2);
        check("t3_grant3", 32'(order[3]), 32'd2);
`endif
        check("t3_grant4", 32'(order[4]), 32'd1);

        // Reset asserted while a data write is stalled.
        nxt(); db_address = 32'h40; db_writedata = 32'h1234; db_byteenable = 4'hF;
        db_write = 1'b1; m_waitrequest = 1'b1;
        obs();
        nxt(); obs(); check("t6_m_write_before", 32'(m_write), 32'd1);
        nxt(); rst_n = 1'b0; #1;
        check("t6_m_write_async", 32'(m_write), 32'd0);
        check("t6_db_waitrequest", 32'(db_waitrequest), 32'd1);
        check("t6_ib_waitrequest", 32'(ib_waitrequest), 32'd1);
        db_write = 1'b0;
        obs();
        nxt(); rst_n = 1'b1; ib_address = 32'h300; ib_read = 1'b1;
        m_waitrequest = 1'b0; m_readdata = 32'h600D_F00D;
        obs();
        nxt(); obs();
        check("t6_ib_after_reset_wait", 32'(ib_waitrequest), 32'd0);
        check("t6_ib_after_reset_data", ib_readdata, 32'h600D_F00D);
        nxt(); ib_read = 1'b0;

        // Data read dropped after one wait cycle.
        nxt(); db_address = 32'h80; db_read = 1'b1; m_waitrequest = 1'b1;
        obs();
        nxt(); obs(); check("t7_m_read_wait", 32'(m_read), 32'd1);
        nxt(); db_read = 1'b0; obs(); check("t7_m_read_dropped", 32'(m_read), 32'd0);
        nxt(); obs();
        check("t7_db_waitrequest", 32'(db_waitrequest), 32'd1);
        check("t7_timeout_err", 32'(timeout_err), 32'd0);

        // Slave stuck forever: watchdog aborts after 8 grant cycles.
        nxt(); db_address = 32'hC0; db_read = 1'b1; m_waitrequest = 1'b1; m_readdata = 32'h9999;
        obs();
        cnt = 0; got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            nxt(); obs();
            if (!db_waitrequest) begin
                got = 1'b1; cnt = c;
                check("t5_db_readdata_abort", db_readdata, DEAD);
                check("t5_m_read_abort", 32'(m_read), 32'd0);
            end
        end
        check("t5_abort_cycle", 32'(cnt), 32'd8);
        nxt(); db_read = 1'b0; obs();
        check("t5_timeout_err_set", 32'(timeout_err), 32'd1);
        nxt(); ib_address = 32'h500; ib_read = 1'b1; m_waitrequest = 1'b0; m_readdata = 32'h77;
        obs();
        nxt(); obs(); check("t5_good_ib_readdata", ib_readdata, 32'h77);
        nxt(); ib_read = 1'b0; obs();
        check("t5_timeout_err_sticky", 32'(timeout_err), 32'd1);
        check("t5_db_readdata_hold", db_readdata, DEAD);
        nxt(); obs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risac_bus_arbiter.md
Name: risac_bus_arbiter

Overview:
- Shares one Avalon-MM slave port (unified on-chip memory) between the risac instruction bus (read-only) and data bus (read/write, byte enables).
- Sits between the risac Avalon wrapper and the memory.
- Runs a registered grant state machine with a wait-timeout watchdog so a stuck slave cannot hang the core.

Parameters:
- AW, 32, address width of all buses
- TIMEOUT_CYCLES, 255, max consecutive slave waitrequest cycles before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ib_address  in  AW  instruction master address
- ib_read  in  1  instruction master read request
- ib_readdata  out  32  instruction read data
- ib_waitrequest  out  1  stall to instruction master
- db_address  in  AW  data master address
- db_read  in  1  data master read request
- db_write  in  1  data master write request
- db_writedata  in  32  data write data
- db_byteenable  in  4  data byte enables
- db_readdata  out  32  data read data
- db_waitrequest  out  1  stall to data master
- m_address  out  AW  slave address
- m_read  out  1  slave read
- m_write  out  1  slave write
- m_writedata  out  32  slave write data
- m_byteenable  out  4  slave byte enables
- m_readdata  in  32  slave read data
- m_waitrequest  in  1  slave stall
- timeout_err  out  1  sticky watchdog abort flag

Behaviour:
- Reset values: state IDLE; m_read=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0; ib/db_waitrequest=1; ib/db_readdata=0; timeout_err=0; wait counter=0.
- States: IDLE, GNT_I, GNT_D.
- IDLE arbitration: sample the requests on the rising edge.
  - db_read|db_write set -> GNT_D.
  - else ib_read -> GNT_I.
  - else stay in IDLE.
  - Fixed priority: data over instruction.
  - Both waitrequests stay 1 while in IDLE.
- GNT_x forwarding: slave outputs are driven combinationally from the granted master.
  - m_read/m_write are gated by the live request.
  - The non-granted master sees waitrequest=1.
  - The granted master sees waitrequest=m_waitrequest, and its readdata=m_readdata when m_waitrequest=0.
  - GNT_I always drives m_write=0 and m_byteenable=4'hF.
- Completion: granted request high and m_waitrequest=0 -> transfer done that cycle; next state IDLE.
- Minimum occupancy: 2 cycles per transfer (1 arbitration + 1 data). Back-to-back transfers from one master pay 1 idle cycle each.
- Request dropped mid-grant (protocol violation): deassert m_read/m_write the same cycle, return to IDLE, no error flag.
- Readdata holds: ib/db_readdata register the value on completion and hold it until the next completion for that master, so risac can sample after the waitrequest falling edge.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each cycle in GNT_x with m_waitrequest=1.
  - Counter clears on IDLE entry.
  - When counter==TIMEOUT_CYCLES-1 and waitrequest is still 1: force completion. The granted master gets waitrequest=0, readdata=32'hDEADBEEF, m_read/m_write=0 that cycle; timeout_err<=1 (sticky until reset); next state IDLE.
- Simultaneous events: new requests arriving during GNT_x wait; they are re-arbitrated in IDLE.
- Reset asserted mid-transfer: immediate return to reset values; the slave sees the request drop asynchronously.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the IDLE tie-break uses a 1-bit last-grant register (reset = instruction). When both masters request, the master not granted last wins; last-grant updates on each GNT entry.
- Undefined: fixed data-over-instruction priority, no last-grant register.

Test Plan:
- Single ib read, addr 0x100, slave waitrequest 2 cycles, readdata 0x00000013 -> m_read high 3 cycles, ib_waitrequest falls on cycle 3 with ib_readdata=0x13, state back to IDLE.
- db write addr 0x2004, data 0xA5A5A5A5, byteenable 4'b0011, zero-wait slave -> m_write=1 exactly 1 cycle with matching address/data/byteenable; ib_waitrequest stays 1.
- ib_read and db_read asserted in the same cycle, fixed priority -> data served first, instruction next; with ARB_ROUND_ROBIN_EN, 4 repeated contended rounds alternate D,I,D,I.
- Slave holds waitrequest forever, TIMEOUT_CYCLES=8 -> after 8 grant cycles db_waitrequest=0, db_readdata=0xDEADBEEF, timeout_err=1 and stays 1 across later good transfers.
- rst_n pulled low mid-GNT_D -> m_write=0 immediately, both waitrequests=1; after release the first ib_read is served normally.
- db_read dropped after 1 wait cycle -> m_read=0 same cycle, IDLE next, timeout_err stays 0.
